// File: rtl/enigma_pkg.sv
// Shared types and constants for the rotor configuration / stepping path.
package enigma_pkg;

  localparam int unsigned NUM_LETTERS  = 26;
  localparam int unsigned LETTER_W     = 5;
  localparam int unsigned NUM_ROTORS   = 3;
  localparam int unsigned NOTCH_1_DEF  = 16;  // 'Q' on the fast rotor
  localparam int unsigned NOTCH_2_DEF  = 4;   // 'E' on the middle rotor

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {
    S_UNCONF = 2'd0,
    S_READY  = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_ROTOR_1 = 2'b00,
    SEL_ROTOR_2 = 2'b01,
    SEL_ROTOR_3 = 2'b10,
    SEL_COMMIT  = 2'b11
  } sel_t;

  // Modulo-alphabet increment; compares before wrapping so 26..31 never appear.
  function automatic letter_t letter_inc(input letter_t x);
    return (x == letter_t'(NUM_LETTERS - 1)) ? '0 : x + letter_t'(1);
  endfunction

endpackage

// File: rtl/rotor_counter.sv
// One rotor position register with load, mod-alphabet increment and notch flag.
//   clk, rst      : clock, async active-low reset
//   load/load_val : overwrite the position (wins over inc)
//   inc           : advance one position, wrapping to 0
//   pos           : registered position
//   at_notch      : pos equals NOTCH (decoded from the registered position)
module rotor_counter
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  letter_t load_val,
  input  logic    inc,
  output letter_t pos,
  output logic    at_notch
);

  // Position register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos <= '0;
    end else if (load) begin
      pos <= load_val;
    end else if (inc) begin
      pos <= letter_inc(pos);
    end
  end

  assign at_notch = (pos == letter_t'(NOTCH));

endmodule

// File: rtl/rotor_stepper.sv
// Rotor stepper: captures per-rotor initial positions into shadows, commits them
// atomically to the live rotors, then steps the rotors once per accepted key using
// odometer stepping with the middle-rotor double step.
//   clk, rst                : clock, async active-low reset
//   cfg_valid / cfg_ready   : configuration beat handshake
//   pozitie_rotor_in        : 0..2 selects rotor 1..3, 3 = commit
//   pozitie_initiala_in     : initial position for the selected rotor
//   key_valid / key_ready   : keypress handshake (config has priority)
//   step_done               : pulse, positions show the stepped values
//   configured              : sticky, a commit has succeeded since reset
//   cfg_error               : pulse, previous config beat was rejected
//   pozitie_rotor_1/2/3     : live rotor positions
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH_1 = NOTCH_1_DEF,
  parameter int unsigned NOTCH_2 = NOTCH_2_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] pozitie_rotor_in,
  input  logic [4:0] pozitie_initiala_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       step_done,
  output logic       configured,
  output logic       cfg_error,
  output logic [4:0] pozitie_rotor_1,
  output logic [4:0] pozitie_rotor_2,
  output logic [4:0] pozitie_rotor_3
);

  state_t  state, next_state;

  letter_t shadow  [NUM_ROTORS];
  logic    written [NUM_ROTORS];

  logic    cfg_fire, key_fire;
  logic    is_commit, val_ok, all_written;
  logic    commit_ok, cfg_reject;
  logic    notch_1, notch_2, notch_3_unused;

  // Handshake decode from state; key is held off while a config beat is offered
  always_comb begin
    cfg_ready = 1'b0;
    key_ready = 1'b0;
    case (state)
      S_UNCONF: cfg_ready = 1'b1;
      S_READY: begin
        cfg_ready = 1'b1;
        key_ready = ~cfg_valid;
      end
      default: ;
    endcase
  end

  assign cfg_fire    = cfg_valid & cfg_ready;
  assign key_fire    = key_valid & key_ready;
  assign is_commit   = (sel_t'(pozitie_rotor_in) == SEL_COMMIT);
  assign val_ok      = (pozitie_initiala_in < letter_t'(NUM_LETTERS));
  assign all_written = written[0] & written[1] & written[2];
  assign commit_ok   = cfg_fire & is_commit & all_written;
  assign cfg_reject  = cfg_fire & (is_commit ? ~all_written : ~val_ok);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_UNCONF;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_UNCONF: if (commit_ok) next_state = S_READY;
      S_READY:  if (key_fire)  next_state = S_STEP;
      S_STEP:   next_state = S_READY;
      default:  next_state = S_UNCONF;
    endcase
  end

  // Shadow registers and their written flags; a good commit clears all flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_ROTORS); i++) begin
        shadow[i]  <= '0;
        written[i] <= 1'b0;
      end
    end else if (commit_ok) begin
      for (int i = 0; i < int'(NUM_ROTORS); i++) begin
        written[i] <= 1'b0;
      end
    end else if (cfg_fire && !is_commit && val_ok) begin
      for (int i = 0; i < int'(NUM_ROTORS); i++) begin
        if (pozitie_rotor_in == 2'(i)) begin
          shadow[i]  <= pozitie_initiala_in;
          written[i] <= 1'b1;
        end
      end
    end
  end

  // Status pulses and sticky configured flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_done  <= 1'b0;
      cfg_error  <= 1'b0;
      configured <= 1'b0;
    end else begin
      step_done  <= key_fire;
      cfg_error  <= cfg_reject;
      if (commit_ok) configured <= 1'b1;
    end
  end

  // Live rotors; all step enables come from the pre-step positions
  rotor_counter #(.NOTCH(NOTCH_1)) u_rotor_1 (
    .clk      (clk),
    .rst      (rst),
    .load     (commit_ok),
    .load_val (shadow[0]),
    .inc      (key_fire),
    .pos      (pozitie_rotor_1),
    .at_notch (notch_1)
  );

  // Middle rotor steps on the fast rotor's notch or its own (double step)
  rotor_counter #(.NOTCH(NOTCH_2)) u_rotor_2 (
    .clk      (clk),
    .rst      (rst),
    .load     (commit_ok),
    .load_val (shadow[1]),
    .inc      (key_fire & (notch_1 | notch_2)),
    .pos      (pozitie_rotor_2),
    .at_notch (notch_2)
  );

  // Slow rotor has no downstream rotor, so its notch flag is not consumed
  rotor_counter #(.NOTCH(0)) u_rotor_3 (
    .clk      (clk),
    .rst      (rst),
    .load     (commit_ok),
    .load_val (shadow[2]),
    .inc      (key_fire & notch_2),
    .pos      (pozitie_rotor_3),
    .at_notch (notch_3_unused)
  );

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper with a scoreboard of expected positions.
module tb_rotor_stepper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] pozitie_rotor_in = '0;
  logic [4:0] pozitie_initiala_in = '0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       step_done;
  logic       configured;
  logic       cfg_error;
  logic [4:0] pozitie_rotor_1, pozitie_rotor_2, pozitie_rotor_3;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int r1;
    int r2;
    int r3;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m1, m2, m3;
  int sh [3];
  bit fl [3];
  int mconf;

  rotor_stepper dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .pozitie_rotor_in    (pozitie_rotor_in),
    .pozitie_initiala_in (pozitie_initiala_in),
    .key_valid           (key_valid),
    .key_ready           (key_ready),
    .step_done           (step_done),
    .configured          (configured),
    .cfg_error           (cfg_error),
    .pozitie_rotor_1     (pozitie_rotor_1),
    .pozitie_rotor_2     (pozitie_rotor_2),
    .pozitie_rotor_3     (pozitie_rotor_3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".r1"}, int'(pozitie_rotor_1), m1);
    check({tag, ".r2"}, int'(pozitie_rotor_2), m2);
    check({tag, ".r3"}, int'(pozitie_rotor_3), m3);
  endtask

  task automatic model_reset();
    m1 = 0; m2 = 0; m3 = 0; mconf = 0;
    for (int i = 0; i < 3; i++) begin
      sh[i] = 0;
      fl[i] = 1'b0;
    end
  endtask

  // Enigma odometer step from pre-step positions, written from the textbook rule
  task automatic model_step();
    bit s2, s3;
    s2 = (m1 == 16) || (m2 == 4);
    s3 = (m2 == 4);
    m1 = (m1 + 1) % 26;
    if (s2) m2 = (m2 + 1) % 26;
    if (s3) m3 = (m3 + 1) % 26;
  endtask

  // Scoreboard: every step_done pops one expected position triple
  always @(negedge clk) begin
    if (rst && step_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb.r1", int'(pozitie_rotor_1), e.r1);
        check("sb.r2", int'(pozitie_rotor_2), e.r2);
        check("sb.r3", int'(pozitie_rotor_3), e.r3);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    cfg_valid = 1'b0;
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // One configuration beat; expected error and model update derived here
  task automatic cfg_beat(input int sel, input int val);
    int exp_err;
    if (sel == 3) begin
      exp_err = (fl[0] && fl[1] && fl[2]) ? 0 : 1;
      if (exp_err == 0) begin
        m1 = sh[0]; m2 = sh[1]; m3 = sh[2];
        for (int i = 0; i < 3; i++) fl[i] = 1'b0;
        mconf = 1;
      end
    end else if (val >= 26) begin
      exp_err = 1;
    end else begin
      sh[sel] = val;
      fl[sel] = 1'b1;
      exp_err = 0;
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    pozitie_rotor_in = 2'(sel);
    pozitie_initiala_in = 5'(val);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_error", int'(cfg_error), exp_err);
    check("configured", int'(configured), mconf);
    check_pos("cfg_pos");
  endtask

  task automatic load3(input int a, input int b, input int c);
    cfg_beat(0, a);
    cfg_beat(1, b);
    cfg_beat(2, c);
    cfg_beat(3, 0);
  endtask

  task automatic press_key();
    exp_t e;
    @(negedge clk);
    key_valid = 1'b1;
    #1;
    check("key_ready", int'(key_ready), 1);
    model_step();
    e.r1 = m1; e.r2 = m2; e.r3 = m3;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    check("step_done_latency", int'(step_done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // 1: keys ignored while unconfigured
    @(negedge clk);
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("unconf.key_ready", int'(key_ready), 0);
      check("unconf.configured", int'(configured), 0);
      check("unconf.step_done", int'(step_done), 0);
      check_pos("unconf");
    end
    key_valid = 1'b0;

    // 2: basic configure and one key
    load3(3, 7, 11);
    press_key();

    // 3: notch and double step
    load3(16, 3, 0);
    repeat (3) press_key();

    // 4: wrap cases
    load3(25, 25, 25);
    press_key();
    load3(25, 4, 25);
    press_key();

    // 5a: out-of-range value rejected, shadow retains previous value
    cfg_beat(0, 9);
    cfg_beat(0, 26);
    // 5b: commit with rotor 3 unwritten rejected
    cfg_beat(1, 12);
    cfg_beat(3, 0);
    // finish configuration: rotor 1 must still be 9
    cfg_beat(2, 1);
    cfg_beat(3, 0);
    check("shadow_kept", int'(pozitie_rotor_1), 9);

    // 5c: config and key together: key held off
    @(negedge clk);
    cfg_valid = 1'b1;
    pozitie_rotor_in = 2'd0;
    pozitie_initiala_in = 5'd2;
    key_valid = 1'b1;
    sh[0] = 2; fl[0] = 1'b1;
    #1;
    check("prio.key_ready", int'(key_ready), 0);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    key_valid = 1'b0;
    check("prio.step_done", int'(step_done), 0);
    check_pos("prio");
    press_key();

    // 6: async reset in the middle of a step
    @(negedge clk);
    key_valid = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check("mid.step_done", int'(step_done), 1);
    check_pos("mid_step");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst.step_done", int'(step_done), 0);
    check("rst.key_ready", int'(key_ready), 0);
    check("rst.configured", int'(configured), 0);
    check_pos("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst.cfg_ready", int'(cfg_ready), 1);
    check("rst.key_ready_after", int'(key_ready), 0);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
